scan_chain_mc: RTL

Parametrised multi-chain scan register with a single clock, replacing the two-phase single-chain scan chain in front of the Kyber core. Configuration bits are split across NUM_CHAINS parallel serial chains to cut load time. A built-in shift counter guards against partial or over-length loads. Capture samples core status into the chains, and update transfers the shifted image to the core-facing register, optionally only when exactly one chain length has been shifted.

---
 rtl/scan_chain_mc.sv | 73 +++++++
 1 files changed

// File: rtl/scan_chain_mc.sv
// scan_chain_mc: multi-chain scan register with capture, shift-count guarded update
// and a registered reject pulse; capture beats shift beats update on each edge.
module scan_chain_mc #(
    parameter int NUM_SCAN_BITS = 523,
    parameter int NUM_CHAINS    = 4,
    parameter int STRICT_UPDATE = 1,
    localparam int CHAIN_LEN    = (NUM_SCAN_BITS + NUM_CHAINS - 1) / NUM_CHAINS,
    localparam int PW           = NUM_CHAINS * CHAIN_LEN,
    localparam int CW           = $clog2(CHAIN_LEN + 2)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scan_en,
    input  logic                     capture,
    input  logic                     update,
    input  logic [NUM_SCAN_BITS-1:0] par_in,
    input  logic [NUM_CHAINS-1:0]    scan_in,
    output logic [NUM_CHAINS-1:0]    scan_out,
    output logic [NUM_SCAN_BITS-1:0] scan_reg,
    output logic [CW-1:0]            shift_cnt,
    output logic                     load_ok,
    output logic                     update_err
);
    logic [PW-1:0]            sh_q, sh_d, shifted;
    logic [NUM_SCAN_BITS-1:0] reg_q, reg_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     err_q, err_d;
    for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_ch
        logic [CHAIN_LEN:0] seg;
        assign seg = {scan_in[c], sh_q[c*CHAIN_LEN +: CHAIN_LEN]};
        assign shifted[c*CHAIN_LEN +: CHAIN_LEN] = seg[CHAIN_LEN:1];
        assign scan_out[c] = sh_q[c*CHAIN_LEN];
    end
    assign load_ok    = cnt_q == CW'(CHAIN_LEN);
    assign scan_reg   = reg_q;
    assign shift_cnt  = cnt_q;
    assign update_err = err_q;
    always_comb begin
        sh_d  = sh_q;
        reg_d = reg_q;
        cnt_d = cnt_q;
        err_d = 1'b0;
        if (capture) begin
            sh_d  = PW'(par_in);
            cnt_d = '0;
        end else if (scan_en) begin
            sh_d  = shifted;
            cnt_d = (cnt_q == CW'(CHAIN_LEN + 1)) ? cnt_q : cnt_q + 1'b1;
            err_d = update;
        end else if (update) begin
            // pad bits above NUM_SCAN_BITS are dropped here
            if (STRICT_UPDATE == 0 || load_ok) begin
                reg_d = sh_q[NUM_SCAN_BITS-1:0];
                cnt_d = '0;
            end else begin
                err_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            reg_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            reg_q <= reg_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
endmodule
